// File: rtl/sensor_mux_pkg.sv
// Shared types and helpers for the sensor scan multiplexer.
package sensor_mux_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAN,
        ST_SCAN,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // LSB position of channel ch in a flattened bus of width-bit channels.
    function automatic int unsigned slice_lsb(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/sensor_scan_mux_chan_select.sv
// Combinational NCH:1 channel mux; selects beyond the last channel clamp to NCH-1.
module chan_select
    import sensor_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic [NCH*WIDTH-1:0] ch_data,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     data_c,
    output logic [SELW-1:0]      ch_c
);

    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

    logic [WIDTH-1:0] chans [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        assign chans[k] = ch_data[slice_lsb(k, WIDTH) +: WIDTH];
    end

    assign ch_c = (32'(sel) >= NCH) ? LAST_CH : sel;

    always_comb begin
        data_c = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (ch_c == SELW'(k)) begin
                data_c = chans[k];
            end
        end
    end

endmodule

// File: rtl/sensor_scan_mux.sv
// Light-sensor channel mux: manual select or round-robin scan that reports the brightest channel.
module sensor_scan_mux
    import sensor_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] ch_data,
    input  logic                 mode,
    input  logic [SELW-1:0]      man_sel,
    input  logic                 start,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      best_ch,
    output logic [WIDTH-1:0]     best_val,
    output logic                 sweep_done,
    output logic                 busy
);

    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

    state_t           state, state_n;
    logic [SELW-1:0]  idx, idx_n;
    logic [SELW-1:0]  max_ch, max_ch_n;
    logic [WIDTH-1:0] max_val, max_val_n;
    logic [WIDTH-1:0] out_data_n;
    logic [SELW-1:0]  out_ch_n;
    logic             out_valid_n;
    logic [SELW-1:0]  best_ch_n;
    logic [WIDTH-1:0] best_val_n;
    logic             sweep_done_n;
    logic             busy_n;

    logic [SELW-1:0]  sel_c;
    logic [WIDTH-1:0] sel_data_c;
    logic [SELW-1:0]  sel_ch_c;
    logic             accept_c;
    logic             free_c;

    // One shared mux: the manual select drives it only while in MAN.
    assign sel_c    = (state == ST_MAN) ? man_sel : idx;
    assign accept_c = out_valid && out_ready;
    assign free_c   = !out_valid || out_ready;

    chan_select #(
        .WIDTH (WIDTH),
        .NCH   (NCH),
        .SELW  (SELW)
    ) u_chan_select (
        .ch_data (ch_data),
        .sel     (sel_c),
        .data_c  (sel_data_c),
        .ch_c    (sel_ch_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            max_ch     <= '0;
            max_val    <= '0;
            out_data   <= '0;
            out_ch     <= '0;
            out_valid  <= 1'b0;
            best_ch    <= '0;
            best_val   <= '0;
            sweep_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            max_ch     <= max_ch_n;
            max_val    <= max_val_n;
            out_data   <= out_data_n;
            out_ch     <= out_ch_n;
            out_valid  <= out_valid_n;
            best_ch    <= best_ch_n;
            best_val   <= best_val_n;
            sweep_done <= sweep_done_n;
            busy       <= busy_n;
        end
    end

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        max_ch_n     = max_ch;
        max_val_n    = max_val;
        out_data_n   = out_data;
        out_ch_n     = out_ch;
        out_valid_n  = out_valid;
        best_ch_n    = best_ch;
        best_val_n   = best_val;
        sweep_done_n = 1'b0;
        busy_n       = busy;

        case (state)
            ST_IDLE: begin
                if (mode == MODE_MANUAL) begin
                    state_n = ST_MAN;
                end else if (start) begin
                    state_n   = ST_SCAN;
                    idx_n     = '0;
                    max_val_n = '0;
                    max_ch_n  = '0;
                    busy_n    = 1'b1;
                end
            end
            ST_MAN: begin
                // Leave only with no beat pending so a presented sample is never dropped.
                if (free_c) begin
                    if (mode == MODE_SCAN) begin
                        out_valid_n = 1'b0;
                        state_n     = ST_IDLE;
                    end else begin
                        out_data_n  = sel_data_c;
                        out_ch_n    = sel_ch_c;
                        out_valid_n = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                out_data_n  = sel_data_c;
                out_ch_n    = sel_ch_c;
                out_valid_n = 1'b1;
                // Strict compare keeps the lower index on ties; channel 0 always seeds the max.
                if ((idx == '0) || (sel_data_c > max_val)) begin
                    max_val_n = sel_data_c;
                    max_ch_n  = idx;
                end
                state_n = ST_HOLD;
            end
            ST_HOLD: begin
                if (accept_c) begin
                    out_valid_n = 1'b0;
                    if (idx == LAST_CH) begin
                        state_n = ST_DONE;
                    end else begin
                        idx_n   = idx + SELW'(1);
                        state_n = ST_SCAN;
                    end
                end
            end
            ST_DONE: begin
                best_ch_n    = max_ch;
                best_val_n   = max_val;
                sweep_done_n = 1'b1;
                busy_n       = 1'b0;
                state_n      = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sensor_scan_mux.sv
// Directed plus randomized bench for sensor_scan_mux against a behavioural channel/argmax model.
module tb_sensor_scan_mux;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned NCH   = 4;
    localparam int unsigned SELW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH*WIDTH-1:0] ch_data;
    logic                 mode;
    logic [SELW-1:0]      man_sel;
    logic                 start;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;
    logic [SELW-1:0]      best_ch;
    logic [WIDTH-1:0]     best_val;
    logic                 sweep_done;
    logic                 busy;

    always #5 clk = ~clk;

    sensor_scan_mux #(
        .WIDTH (WIDTH),
        .NCH   (NCH),
        .SELW  (SELW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_data    (ch_data),
        .mode       (mode),
        .man_sel    (man_sel),
        .start      (start),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .best_ch    (best_ch),
        .best_val   (best_val),
        .sweep_done (sweep_done),
        .busy       (busy)
    );

    int unsigned passed = 0;
    int unsigned failed = 0;
    int unsigned total  = 0;

    // Manual-path model and last reported sweep result.
    logic [WIDTH-1:0] m_data;
    logic [SELW-1:0]  m_ch;
    logic             m_valid;
    logic [SELW-1:0]  exp_best_ch;
    logic [WIDTH-1:0] exp_best_val;

    logic [WIDTH-1:0] t2_exp [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] chan(input logic [NCH*WIDTH-1:0] d, input int unsigned k);
        return WIDTH'((d >> (WIDTH * k)) & 16'hF);
    endfunction

    function automatic int unsigned clamp(input int unsigned s);
        return (s >= NCH) ? NCH - 1 : s;
    endfunction

    function automatic int unsigned argmax(input logic [NCH*WIDTH-1:0] d);
        int unsigned b = 0;
        for (int unsigned k = 1; k < NCH; k++) begin
            if (chan(d, k) > chan(d, b)) b = k;
        end
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One MANUAL cycle: advance the model with the inputs seen at the edge, then compare.
    task automatic man_cycle(input string tag);
        if (!m_valid || out_ready) begin
            m_ch    = SELW'(clamp(32'(man_sel)));
            m_data  = chan(ch_data, clamp(32'(man_sel)));
            m_valid = 1'b1;
        end
        step();
        check({tag, ".data"},  32'(out_data),  32'(m_data));
        check({tag, ".ch"},    32'(out_ch),    32'(m_ch));
        check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    endtask

    task automatic run_sweep(input logic [NCH*WIDTH-1:0] d, input bit rand_ready,
                             input bit dup_start, input string tag);
        int unsigned nbeat    = 0;
        int unsigned ndone    = 0;
        int unsigned cyc      = 0;
        int unsigned done_cyc = 0;
        int unsigned best     = argmax(d);
        ch_data   = d;
        mode      = 1'b1;
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        check({tag, ".busy_rise"}, 32'(busy), 32'd1);
        check({tag, ".best_hold"}, 32'({best_ch, best_val}), 32'({exp_best_ch, exp_best_val}));
        while (cyc < 200 && !(ndone > 0 && cyc >= done_cyc + 4)) begin
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            start     = dup_start && (cyc == 3);
            if (out_valid && out_ready) begin
                check({tag, ".beat_ch"},   32'(out_ch),   nbeat);
                check({tag, ".beat_data"}, 32'(out_data), 32'(chan(d, nbeat)));
                nbeat++;
            end
            step();
            cyc++;
            if (sweep_done) begin
                ndone++;
                done_cyc = cyc;
            end
        end
        start = 1'b0;
        check({tag, ".nbeat"}, nbeat, NCH);
        check({tag, ".ndone"}, ndone, 1);
        if (!rand_ready) check({tag, ".done_cyc"}, done_cyc, 2 * NCH + 1);
        check({tag, ".best_ch"},  32'(best_ch),  best);
        check({tag, ".best_val"}, 32'(best_val), 32'(chan(d, best)));
        check({tag, ".busy_low"}, 32'(busy), 32'd0);
        exp_best_ch  = SELW'(best);
        exp_best_val = chan(d, best);
    endtask

    initial begin
        #1000000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned cyc;
        int unsigned ndone;
        t2_exp       = '{4'h9, 4'h3, 4'h7, 4'hD};
        rst          = 1'b1;
        ch_data      = '0;
        mode         = 1'b0;
        man_sel      = '0;
        start        = 1'b0;
        out_ready    = 1'b0;
        m_valid      = 1'b0;
        m_data       = '0;
        m_ch         = '0;
        exp_best_ch  = '0;
        exp_best_val = '0;

        // Power-up reset values.
        step();
        check("reset.outs", 32'({out_data, out_ch, out_valid, best_ch, best_val, sweep_done, busy}), 32'd0);
        rst = 1'b0;

        // MANUAL stepping with the reference pattern.
        ch_data   = 16'hD739;
        out_ready = 1'b1;
        step();
        check("man.enter_valid", 32'(out_valid), 32'd0);
        for (int unsigned k = 0; k < NCH; k++) begin
            man_sel = SELW'(k);
            man_cycle("man.step");
            check("man.table", 32'(out_data), 32'(t2_exp[k]));
        end

        // Randomized MANUAL traffic with random backpressure.
        for (int i = 0; i < 24; i++) begin
            ch_data   = 16'($urandom);
            man_sel   = SELW'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            man_cycle("man.rand");
        end

        // Backpressure: outputs frozen while inputs move, then release.
        out_ready = 1'b1;
        man_cycle("bp.prime");
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ch_data = 16'($urandom);
            man_sel = SELW'($urandom);
            man_cycle("bp.hold");
        end
        ch_data   = 16'hD739;
        man_sel   = 2'd2;
        out_ready = 1'b1;
        man_cycle("bp.release");

        // Asynchronous reset mid-cycle clears outputs before the next edge.
        #2 rst = 1'b1;
        #1;
        check("reset.async", 32'({out_data, out_ch, out_valid, best_ch, best_val, sweep_done, busy}), 32'd0);
        step();
        rst     = 1'b0;
        m_valid = 1'b0;
        step();
        check("man.reenter_valid", 32'(out_valid), 32'd0);
        man_cycle("man.after_reset");

        // Leave MANUAL for SCAN.
        mode      = 1'b1;
        out_ready = 1'b1;
        step();
        check("man.exit_valid", 32'(out_valid), 32'd0);

        run_sweep(16'hD739, 1'b0, 1'b0, "scan");
        check("scan.best_lit", 32'({best_ch, best_val}), 32'h3D);

        run_sweep(16'h5AA2, 1'b0, 1'b1, "tie");
        check("tie.best_lit", 32'({best_ch, best_val}), 32'h1A);

        // Reset while holding channel 2's beat aborts the sweep.
        ch_data   = 16'hD739;
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        cyc   = 0;
        while (!(out_valid && out_ch == 2'd2) && cyc < 50) begin
            step();
            cyc++;
        end
        out_ready = 1'b0;
        check("abort.reach_ch2", 32'({out_valid, out_ch}), 32'h6);
        #2 rst = 1'b1;
        #1;
        check("abort.valid", 32'(out_valid), 32'd0);
        check("abort.busy",  32'(busy),      32'd0);
        check("abort.best",  32'({best_ch, best_val}), 32'd0);
        step();
        rst          = 1'b0;
        out_ready    = 1'b1;
        exp_best_ch  = '0;
        exp_best_val = '0;
        ndone        = 0;
        for (int i = 0; i < int'(2 * NCH + 4); i++) begin
            step();
            if (sweep_done) ndone++;
        end
        check("abort.no_done", ndone, 0);
        run_sweep(16'h1234, 1'b0, 1'b0, "clean");

        // All-zero sweep reports channel 0, then randomized sweeps with backpressure.
        run_sweep(16'h0000, 1'b0, 1'b0, "zero");
        for (int i = 0; i < 3; i++) begin
            run_sweep(16'($urandom), 1'b1, 1'($urandom_range(0, 1)), "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sensor_scan_mux.md
Name: sensor_scan_mux

Overview:
Parametrised successor to the 2:1 sensor-bus multiplexer. It selects one of NCH light-sensor channels, each WIDTH bits wide, and presents the registered sample on a valid/ready stream. In MANUAL mode it follows an external select. In SCAN mode it sweeps all channels round-robin and reports the brightest channel, which the angle controller uses as its next pointing target.

Parameters:
WIDTH, 4, sample width per channel in bits
NCH, 4, number of input channels (2..16)
SELW, 2, select width; must be at least clog2(NCH)

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-high reset
ch_data  in  NCH*WIDTH  flattened channel samples; channel k occupies bits [k*WIDTH +: WIDTH]
mode  in  1  0 = MANUAL, 1 = SCAN; sampled only in IDLE
man_sel  in  SELW  channel select used in MANUAL mode
start  in  1  single-cycle pulse; starts one SCAN sweep
out_data  out  WIDTH  registered selected sample
out_ch  out  SELW  channel index of out_data
out_valid  out  1  out_data/out_ch valid
out_ready  in  1  downstream accepts the beat
best_ch  out  SELW  brightest channel of the last completed sweep
best_val  out  WIDTH  sample value of best_ch
sweep_done  out  1  one-cycle pulse when a sweep completes
busy  out  1  high while a sweep is in progress

Behaviour:
- Reset (async, rst=1): all outputs 0, FSM in IDLE, scan index 0, running max 0.
- Handshake: a beat transfers when out_valid && out_ready. While out_valid=1 && out_ready=0, out_data and out_ch hold stable.
- FSM states: IDLE, MAN, SCAN, HOLD, DONE.
- IDLE:
  - mode=0 -> MAN next cycle.
  - mode=1 && start -> SCAN with idx=0, max=0, maxch=0, busy=1.
  - mode=1 && !start -> stay in IDLE.
- MAN:
  - Each cycle where (!out_valid || out_ready): out_data<=ch_data[man_sel], out_ch<=man_sel, out_valid<=1. Latency is 1 clk from man_sel to out_data.
  - man_sel >= NCH selects channel NCH-1 (clamp). out_ch reports the clamped value.
  - mode=1 -> return to IDLE once no beat is pending (out_valid=0 or accepted this cycle). start is ignored while in MAN.
- SCAN:
  - Load out_data<=ch_data[idx], out_ch<=idx, out_valid<=1, then go to HOLD.
  - Compare ch_data[idx] > max, unsigned and strict. On a win, max<=value and maxch<=idx. Ties keep the lower index.
  - idx=0 always writes max (initial value 0, and >= applies for idx 0 only), so an all-zero sweep gives best_ch=0.
- HOLD:
  - Wait for acceptance. On accept, out_valid<=0.
  - If idx==NCH-1 -> DONE; else idx<=idx+1 and go to SCAN.
  - Each channel costs at least 2 clk, so a sweep with out_ready tied high takes 2*NCH clk.
- DONE (1 clk): best_ch<=maxch, best_val<=max, sweep_done=1, busy<=0, then IDLE.
- best_ch and best_val change only in DONE and hold otherwise.
- start while busy is ignored. mode changes during SCAN/HOLD take effect only after DONE.
- Reset mid-sweep: immediate abort. best_* clear to 0 and no sweep_done pulse is generated.
- idx wraps only via DONE and never exceeds NCH-1.

Decomposition:
- Package sensor_mux_pkg holds:
  - the FSM state enum (IDLE/MAN/SCAN/HOLD/DONE);
  - the MODE_MANUAL/MODE_SCAN constants;
  - a channel-slice helper function.
- One sub-module, chan_select: a combinational NCH:1 WIDTH-bit mux with clamp. It is the generalised form of the existing 2:1 multiplexer and is instantiated twice (manual path and scan path), or once behind a select mux.

Test Plan:
1. Reset: assert rst mid-cycle -> all outputs 0 asynchronously, before the next edge.
2. MANUAL, out_ready=1, man_sel stepping 0..3, ch_data={4'hD,4'h7,4'h3,4'h9} (ch0 on the right) -> out_data 9,3,7,D, each 1 clk after its select, out_ch matching.
3. MANUAL backpressure: out_ready=0 for 5 clk while man_sel changes -> out_data and out_ch frozen. On release, the new value appears on the next cycle.
4. SCAN with the same ch_data and out_ready=1, pulse start -> beats ch0..ch3 at 2-clk spacing, sweep_done at clk 2*NCH+1, best_ch=3, best_val=D, busy low after.
5. SCAN tie: ch_data={4'h5,4'hA,4'hA,4'h2} -> best_ch=1, best_val=A. A second start pulse during busy -> ignored, exactly one sweep_done.
6. rst during HOLD of ch2 -> out_valid=0, busy=0, best_ch=0, no sweep_done pulse. A following start -> a clean sweep beginning at ch0.
